// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side drain stage for the async FIFO (read clock domain).
// Converts the FIFO empty/r_en interface with 1-cycle read latency into a
// valid/ready stream using a small skid buffer sized for full throughput.
// Optional transfer counter enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BUF_DEPTH  = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  fifo_empty,
   output logic                  fifo_r_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   input  logic                  flush,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data
`ifdef FIFO_RD_STREAM_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]  xfer_cnt
`endif
);

   localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
   localparam int unsigned OCC_W = PTR_W + 1;
   localparam int unsigned SUM_W = OCC_W + 1;

   // Elaboration-time parameter sanity check
   if (BUF_DEPTH < 4 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || CNT_WIDTH == 0) begin : g_bad_param
      $error("fifo_rd_stream: BUF_DEPTH must be a power of two >= 4 and CNT_WIDTH >= 1");
   end

   logic [DATA_WIDTH-1:0] r_buf [BUF_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [OCC_W-1:0]      r_occ;
   logic                  r_inflight;
   logic                  r_run;

   logic [SUM_W-1:0]      w_committed;
   logic                  w_issue;
   logic                  w_capture;
   logic                  w_pop;

   // Read issue depends only on local registers, never on m_ready
   assign w_committed = SUM_W'(r_occ) + SUM_W'(r_inflight);
   assign w_issue     = r_run & ~fifo_empty & ~flush & (w_committed < SUM_W'(BUF_DEPTH));
   assign w_capture   = r_inflight & ~flush;
   assign w_pop       = (r_occ != '0) & m_ready & ~flush;

   assign fifo_r_en = w_issue;
   assign m_valid   = (r_occ != '0);
   assign m_data    = r_buf[r_rd_ptr];

   // Holds off reads until the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_run <= 1'b0;
      end else begin
         r_run <= 1'b1;
      end
   end

   // Tracks the read whose data returns next cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_inflight <= 1'b0;
      end else begin
         r_inflight <= w_issue;
      end
   end

   // Buffer storage: capture returned FIFO words at the write pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(BUF_DEPTH); i++) begin
            r_buf[i] <= '0;
         end
      end else if (w_capture) begin
         r_buf[r_wr_ptr] <= fifo_data;
      end
   end

   // Pointer and occupancy bookkeeping; flush clears everything local
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else if (flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_occ    <= '0;
      end else begin
         if (w_capture) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         case ({w_capture, w_pop})
            2'b10:   r_occ <= r_occ + OCC_W'(1);
            2'b01:   r_occ <= r_occ - OCC_W'(1);
            default: r_occ <= r_occ;
         endcase
      end
   end

`ifdef FIFO_RD_STREAM_CNT_EN
   logic [CNT_WIDTH-1:0] r_xfer_cnt;

   // Saturating count of completed transfers; survives flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_xfer_cnt <= '0;
      end else if (w_pop && (r_xfer_cnt != '1)) begin
         r_xfer_cnt <= r_xfer_cnt + CNT_WIDTH'(1);
      end
   end

   assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural 1-cycle-latency FIFO.
module tb_fifo_rd_stream;

   localparam int unsigned DW = 8;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          fifo_empty;
   logic          fifo_r_en;
   logic [DW-1:0] fifo_data;
   logic          flush;
   logic          m_valid;
   logic          m_ready;
   logic [DW-1:0] m_data;
`ifdef FIFO_RD_STREAM_CNT_EN
   logic [3:0]    xfer_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   // FIFO model storage
   logic [DW-1:0] mem [64];
   int            wr_i = 0;
   int            rd_i = 0;

   // Observation
   int            ren_cnt = 0;
   logic [DW-1:0] out_q [256];
   int            out_n = 0;

   always #5 clk = ~clk;

   fifo_rd_stream #(.DATA_WIDTH(DW), .BUF_DEPTH(4), .CNT_WIDTH(4)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_r_en  (fifo_r_en),
      .fifo_data  (fifo_data),
      .flush      (flush),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_data     (m_data)
`ifdef FIFO_RD_STREAM_CNT_EN
      ,
      .xfer_cnt   (xfer_cnt)
`endif
   );

   assign fifo_empty = (rd_i >= wr_i);

   // FIFO read side: registered data one cycle after an accepted read
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_i      <= 0;
         fifo_data <= '0;
      end else if (fifo_r_en) begin
         fifo_data <= mem[rd_i];
         rd_i      <= rd_i + 1;
      end
   end

   // Counts read pulses and records every accepted stream transfer
   always @(posedge clk) begin
      if (rst_n && fifo_r_en) ren_cnt <= ren_cnt + 1;
      if (rst_n && m_valid && m_ready && !flush) begin
         out_q[out_n] <= m_data;
         out_n        <= out_n + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int first, input int n);
      for (int k = 0; k < n; k++) begin
         mem[wr_i] = DW'(first + k);
         wr_i++;
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk_seq(input string tag, input int base, input int first, input int n);
      chk({tag, "_count"}, 32'(out_n - base), 32'(n));
      for (int k = 0; k < n; k++) begin
         chk(tag, 32'(out_q[base + k]), 32'(first + k));
      end
   endtask

   int            base;
   int            ren_base;
   logic          prev_stall;
   logic [DW-1:0] prev_d;

   initial begin
      rst_n   = 1'b0;
      flush   = 1'b0;
      m_ready = 1'b1;
      push(1, 8);

      // Reset with data waiting in the FIFO
      cycles(2);
      chk("rst_r_en", 32'(fifo_r_en), 32'd0);
      chk("rst_valid", 32'(m_valid), 32'd0);
      chk("rst_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
      rst_n = 1'b1;
      #1;
      chk("rel_r_en", 32'(fifo_r_en), 32'd0);

      // Streaming 1..8: first read next cycle, data two cycles later
      base = out_n;
      cycles(1);
      chk("first_r_en", 32'(fifo_r_en), 32'd1);
      chk("lat0_valid", 32'(m_valid), 32'd0);
      cycles(1);
      chk("lat1_valid", 32'(m_valid), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         cycles(1);
         chk("tput_valid", 32'(m_valid), 32'd1);
         chk("tput_data", 32'(m_data), 32'(k));
      end
      cycles(1);
      chk("drained_valid", 32'(m_valid), 32'd0);
      chk_seq("stream", base, 1, 8);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("cnt8", 32'(xfer_cnt), 32'd8);
`endif

      // Downstream stall: exactly BUF_DEPTH reads, then back-pressure
      m_ready  = 1'b0;
      push(9, 8);
      ren_base = ren_cnt;
      base     = out_n;
      cycles(10);
      chk("stall_reads", 32'(ren_cnt - ren_base), 32'd4);
      chk("stall_r_en", 32'(fifo_r_en), 32'd0);
      chk("stall_fifo_nonempty", 32'(fifo_empty), 32'd0);
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_head", 32'(m_data), 32'd9);
      m_ready = 1'b1;
      cycles(15);
      chk_seq("stall_release", base, 9, 8);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("cnt_sat", 32'(xfer_cnt), 32'd15);
`endif

      // Toggled ready: data must hold across every stalled cycle
      push(17, 8);
      base       = out_n;
      prev_stall = 1'b0;
      prev_d     = '0;
      for (int c = 0; c < 30; c++) begin
         cycles(1);
         if (prev_stall) chk("hold_data", 32'(m_data), 32'(prev_d));
         m_ready    = ~m_ready;
         prev_stall = m_valid && !m_ready;
         prev_d     = m_data;
      end
      m_ready = 1'b1;
      cycles(5);
      chk_seq("toggle", base, 17, 8);

      // Flush with 3 buffered words and one read in flight
      m_ready = 1'b0;
      push(25, 3);
      cycles(8);
      chk("pre_flush_r_en", 32'(fifo_r_en), 32'd0);
      push(28, 3);
      #1;
      chk("pre_flush_issue", 32'(fifo_r_en), 32'd1);
      cycles(1);
      flush = 1'b1;
      #1;
      chk("flush_r_en", 32'(fifo_r_en), 32'd0);
      cycles(1);
      flush = 1'b0;
      #1;
      chk("post_flush_valid", 32'(m_valid), 32'd0);
      chk("post_flush_issue", 32'(fifo_r_en), 32'd1);
      base    = out_n;
      m_ready = 1'b1;
      cycles(8);
      chk_seq("flush_resume", base, 29, 2);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("cnt_after_flush", 32'(xfer_cnt), 32'd15);
`endif

      // Asynchronous reset in mid-operation clears outputs at once
      m_ready = 1'b0;
      push(40, 6);
      cycles(6);
      chk("pre_rst_valid", 32'(m_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(m_valid), 32'd0);
      chk("async_rst_r_en", 32'(fifo_r_en), 32'd0);
      chk("async_rst_data", 32'(m_data), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
      chk("async_rst_cnt", 32'(xfer_cnt), 32'd0);
`endif
      wr_i = 0;
      cycles(2);
      push(50, 3);
      rst_n   = 1'b1;
      m_ready = 1'b1;
      base    = out_n;
      cycles(10);
      chk_seq("after_reset", base, 50, 3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
